// File: rtl/cnt_wnd_seq_pkg.sv
// Shared definitions for the window-count blocks: FSM state encoding and a
// constant-foldable ceil(log2) helper.
package cnt_wnd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_chunk_tree.sv
// Combinational popcount of one chunk: pairwise adder tree stored heap-style,
// leaves at node[WIDTH..2*WIDTH-1], root at node[1].
module cnt_chunk_tree
  import cnt_wnd_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]        bits,
  output logic [$clog2(WIDTH):0]  cnt
);

  localparam int unsigned OUT_W = clogb2(WIDTH) + 1;

  logic [OUT_W-1:0] node [1:2*WIDTH-1];

  for (genvar k = 0; k < WIDTH; k++) begin : g_leaf
    assign node[WIDTH+k] = OUT_W'(bits[k]);
  end

  for (genvar k = 1; k < WIDTH; k++) begin : g_sum
    assign node[k] = node[2*k] + node[2*k+1];
  end

  assign cnt = node[1];

endmodule

// File: rtl/cnt_wnd_seq.sv
// Multi-cycle popcount of bitmap[min(len,WND_SIZE)-1:0], one chunk per cycle.
// Optional macro CNT_WND_SEQ_EARLY_EXIT_EN skips trailing fully-masked chunks.
module cnt_wnd_seq
  import cnt_wnd_seq_pkg::*;
#(
  parameter int unsigned WND_SIZE    = 128,
  parameter int unsigned CHUNK_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WND_SIZE-1:0]       req_bitmap,
  input  logic [$clog2(WND_SIZE):0] req_len,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(WND_SIZE):0] rsp_cnt
);

  localparam int unsigned NUM_CHUNKS = WND_SIZE / CHUNK_WIDTH;
  localparam int unsigned WND_LOG    = clogb2(WND_SIZE);
  localparam int unsigned CNT_WIDTH  = WND_LOG + 1;
  localparam int unsigned CHUNK_LOG  = clogb2(CHUNK_WIDTH);
  localparam int unsigned TREE_W     = CHUNK_LOG + 1;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? clogb2(NUM_CHUNKS) : 1;

  cnt_state_e            state_q;
  logic [WND_SIZE-1:0]   bitmap_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  acc_q;
  logic [IDX_W-1:0]      idx_q;

  logic [CNT_WIDTH-1:0]   len_clip_c;
  logic [CNT_WIDTH-1:0]   base_c;
  logic [CHUNK_WIDTH-1:0] chunk_c;
  logic [CHUNK_WIDTH-1:0] mask_c;
  logic [CHUNK_WIDTH-1:0] masked_c;
  logic [TREE_W-1:0]      pop_c;
  logic                   last_c;

  // Length clip, chunk select and per-bit length mask for the current chunk
  always_comb begin
    len_clip_c = (req_len > CNT_WIDTH'(WND_SIZE)) ? CNT_WIDTH'(WND_SIZE) : req_len;
    base_c     = CNT_WIDTH'(idx_q) << CHUNK_LOG;
    chunk_c    = CHUNK_WIDTH'(bitmap_q >> base_c);
    mask_c     = '0;
    for (int unsigned j = 0; j < CHUNK_WIDTH; j++) begin
      mask_c[j] = (base_c + CNT_WIDTH'(j)) < len_q;
    end
    masked_c   = chunk_c & mask_c;
  end

`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
  logic [CNT_WIDTH-1:0] n_chunks_c;

  // Stop after the last chunk that holds any in-range bit
  always_comb begin
    n_chunks_c = (len_q + CNT_WIDTH'(CHUNK_WIDTH - 1)) >> CHUNK_LOG;
    last_c     = (CNT_WIDTH'(idx_q) + CNT_WIDTH'(1)) >= n_chunks_c;
  end
`else
  assign last_c = (idx_q == IDX_W'(NUM_CHUNKS - 1));
`endif

  cnt_chunk_tree #(
    .WIDTH (CHUNK_WIDTH)
  ) u_tree (
    .bits (masked_c),
    .cnt  (pop_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bitmap_q  <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            bitmap_q  <= req_bitmap;
            len_q     <= len_clip_c;
            acc_q     <= '0;
            idx_q     <= '0;
            req_ready <= 1'b0;
`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
            state_q   <= (len_clip_c == '0) ? ST_DONE : ST_RUN;
`else
            state_q   <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          acc_q <= acc_q + CNT_WIDTH'(pop_c);
          idx_q <= idx_q + IDX_W'(1);
          if (last_c) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; it then holds until taken
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_cnt   <= acc_q;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_wnd_seq.sv
// Self-checking bench for cnt_wnd_seq: deadline-based behavioural model checked
// every cycle, plus directed literal cases and randomized traffic.
module tb_cnt_wnd_seq;

  localparam int unsigned WND = 128;
  localparam int unsigned CW  = 16;
`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [WND-1:0] req_bitmap = '0;
  logic [7:0]     req_len = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [7:0]     rsp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cnt_wnd_seq #(
    .WND_SIZE    (WND),
    .CHUNK_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_bitmap (req_bitmap),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_cnt    (rsp_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_cnt(logic [WND-1:0] bm, int len);
    int n;
    int c;
    n = (len > int'(WND)) ? int'(WND) : len;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(bm[i]);
    return c;
  endfunction

  function automatic int ref_lat(int len);
    int n;
    n = (len > int'(WND)) ? int'(WND) : len;
    if (EE) return (n == 0) ? 1 : (n + int'(CW) - 1) / int'(CW) + 1;
    return int'(WND / CW) + 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge T owes its result from edge T+latency
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_due = 0;
  int m_cnt = 0;
  int m_out = 0;
  int n_hs = 0;
  int hs_cyc = -100;
  int acc_cyc = -100;
  int acc_gap = 0;
  int acc_period = 0;

  always @(posedge clk or posedge rst) begin : p_model
    bit vb;
    if (rst) begin
      m_busy = 1'b0;
      m_out  = 0;
    end else begin
      vb = m_busy && (cyc >= m_due);
      cyc++;
      if (rsp_valid && rsp_ready) hs_cyc = cyc;
      if (req_valid && req_ready) begin
        acc_gap    = cyc - hs_cyc;
        acc_period = cyc - acc_cyc;
        acc_cyc    = cyc;
      end
      if (m_busy) begin
        if (vb && rsp_ready) begin
          m_busy = 1'b0;
          n_hs++;
        end
      end else if (req_valid) begin
        m_busy = 1'b1;
        m_due  = cyc + ref_lat(int'(req_len));
        m_cnt  = ref_cnt(req_bitmap, int'(req_len));
      end
      if (m_busy && cyc == m_due) m_out = m_cnt;
    end
  end

  always @(negedge clk) begin
    chk("cyc_req_ready", int'(req_ready), int'(!m_busy));
    chk("cyc_rsp_valid", int'(rsp_valid), int'(m_busy && cyc >= m_due));
    chk("cyc_rsp_cnt", int'(rsp_cnt), m_out);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic txn(string name, logic [WND-1:0] bm, logic [7:0] len, int hold,
                     int exp_cnt, int exp_lat);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin step(); k++; end
    chk({name, "_ready"}, int'(req_ready), 1);
    req_valid = 1'b1; req_bitmap = bm; req_len = len; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin step(); k++; end
    chk({name, "_lat"}, k, exp_lat);
    chk({name, "_cnt"}, int'(rsp_cnt), exp_cnt);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, "_hold_cnt"}, int'(rsp_cnt), exp_cnt);
      chk({name, "_hold_vld"}, int'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({name, "_drop"}, int'(rsp_valid), 0);
  endtask

  initial begin
    logic [WND-1:0] ones;
    logic [WND-1:0] lo16;
    logic [WND-1:0] f0;
    logic [WND-1:0] top;
    int k;
    ones = '1;
    lo16 = 128'hFFFF;
    f0   = {16{8'hF0}};
    top  = 128'h1 << 127;

    chk("model_f0_clip", ref_cnt(f0, 200), 64);
    chk("model_top_127", ref_cnt(top, 127), 0);

    repeat (3) step();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_cnt", int'(rsp_cnt), 0);
    rst = 1'b0;
    step();

    txn("ones128", ones, 8'd128, 5, 128, 9);
    txn("lo16_len10", lo16, 8'd10, 0, 10, EE ? 2 : 9);
    txn("lo16_len0", lo16, 8'd0, 1, 0, EE ? 1 : 9);
    txn("f0_len200", f0, 8'd200, 0, 64, 9);
    txn("top_len127", top, 8'd127, 0, 0, 9);
    txn("top_len128", top, 8'd128, 0, 1, 9);
    txn("ones_len17", ones, 8'd17, 0, 17, EE ? 3 : 9);

    // Reset mid-RUN discards the request
    req_valid = 1'b1; req_bitmap = ones; req_len = 8'd128;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrun_req_ready", int'(req_ready), 1);
    chk("midrun_rsp_valid", int'(rsp_valid), 0);
    chk("midrun_rsp_cnt", int'(rsp_cnt), 0);
    rst = 1'b0;
    repeat (2) step();
    chk("midrun_after_vld", int'(rsp_valid), 0);
    txn("after_run_rst", f0, 8'd100, 0, 48, EE ? 8 : 9);

    // Reset while a result is presented
    req_valid = 1'b1; req_bitmap = ones; req_len = 8'd64;
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin step(); k++; end
    rst = 1'b1;
    step();
    chk("middone_rsp_valid", int'(rsp_valid), 0);
    chk("middone_rsp_cnt", int'(rsp_cnt), 0);
    rst = 1'b0;
    step();
    txn("after_done_rst", lo16, 8'd255, 0, 16, 9);

    // req_valid pulses and new data during RUN are ignored
    req_valid = 1'b1; req_bitmap = ones; req_len = 8'd128;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_bitmap = '0; req_len = 8'd0; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin step(); k++; end
    chk("ignore_cnt", int'(rsp_cnt), 128);
    step();
    rsp_ready = 1'b0;

    // Back-to-back with both sides always willing
    req_valid = 1'b1; req_bitmap = ones; req_len = 8'd128; rsp_ready = 1'b1;
    repeat (40) step();
    req_valid = 1'b0;
    repeat (15) step();
    rsp_ready = 1'b0;
    chk("b2b_gap", acc_gap, 1);
    chk("b2b_period", acc_period, 11);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      req_valid  = ($urandom_range(0, 3) == 0);
      rsp_ready  = ($urandom_range(0, 1) == 1);
      req_bitmap = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 9))
        0: req_len = 8'd0;
        1: req_len = 8'(CW);
        2: req_len = 8'(CW + 1);
        3: req_len = 8'd127;
        4: req_len = 8'd128;
        5: req_len = 8'd200;
        default: req_len = 8'($urandom_range(0, 255));
      endcase
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (15) step();
    chk("rand_progress", int'(n_hs >= 50), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
